// File: rtl/pixdly_pkg.sv
// Shared constants and helpers for the pixel delay line.
// Default geometry: three 8-bit colour channels, a 3-bit sync sideband
// (hsync/vsync/de) and eight shift stages.
package pixdly_pkg;

  localparam int PIXDLY_CH        = 3;
  localparam int PIXDLY_DW        = 8;
  localparam int PIXDLY_CW        = 3;
  localparam int PIXDLY_MAX_DEPTH = 8;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  localparam int PIXDLY_SELW   = clog2(PIXDLY_MAX_DEPTH);
  localparam int PIXDLY_DATA_W = PIXDLY_CH * PIXDLY_DW;

  // LSB position of a channel within a packed multi-channel word.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pixdly_lane.sv
// One W-bit delay lane: a DEPTH-stage shift register that advances on ce,
// a tap mux selected by sel and a registered output. The clr input zeroes
// every stage and the output; data lanes tie it low, the valid lane uses it
// to drop in-flight samples on flush or delay change.
module pixdly_lane
  import pixdly_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int SELW  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            clr,
  input  logic [SELW-1:0] sel,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    dout
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];
  logic [W-1:0] out_q;
  logic [W-1:0] out_d;
  logic [W-1:0] tap_s;

  // Tap mux: pick the stage addressed by sel (sel is already clamped upstream).
  always_comb begin
    tap_s = stage_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      tap_s = (sel == SELW'(i)) ? stage_q[i] : tap_s;
    end
  end

  // Next state: clear wins over advance, stall holds everything.
  always_comb begin
    stage_d = stage_q;
    out_d   = out_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = '0;
      end
      out_d = '0;
    end else if (ce) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
      out_d = tap_s;
    end else begin
      out_d = out_q;
    end
  end

  // Stage and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      out_q <= '0;
    end else begin
      stage_q <= stage_d;
      out_q   <= out_d;
    end
  end

  assign dout = out_q;

endmodule

// File: rtl/pixel_delay_line.sv
// Multi-channel pixel delay line with runtime-selectable latency
// (delay_sel+1 advances), ce stall, valid qualification and frame flush.
// A change of the clamped delay select behaves like a flush so samples are
// never emitted with the wrong alignment.
// Build option: define PIXDLY_SIDEBAND_EN to build the control sideband lane;
// without it in_c is ignored and out_c is tied to zero.
module pixel_delay_line
  import pixdly_pkg::*;
#(
  parameter int CH        = PIXDLY_CH,
  parameter int DW        = PIXDLY_DW,
  parameter int CW        = PIXDLY_CW,
  parameter int MAX_DEPTH = PIXDLY_MAX_DEPTH,
  parameter int SELW      = PIXDLY_SELW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               flush,
  input  logic [SELW-1:0]    delay_sel,
  input  logic               in_valid,
  input  logic [CH*DW-1:0]   in_data,
  input  logic [CW-1:0]      in_c,
  output logic               out_valid,
  output logic [CH*DW-1:0]   out_data,
  output logic [CW-1:0]      out_c,
  output logic               primed
);

  localparam int              FW       = clog2(MAX_DEPTH + 1);
  localparam logic [SELW-1:0] SEL_MAX  = SELW'(MAX_DEPTH - 1);
  localparam logic [FW-1:0]   FILL_MAX = FW'(MAX_DEPTH);

  logic [SELW-1:0] eff_sel_s;
  logic            clr_s;
  logic [SELW-1:0] sel_q;
  logic [SELW-1:0] sel_d;
  logic [FW-1:0]   fill_q;
  logic [FW-1:0]   fill_d;
  logic            primed_q;
  logic            primed_d;

  // Clamp the select, detect a delay change and merge it with flush.
  always_comb begin
    eff_sel_s = (delay_sel > SEL_MAX) ? SEL_MAX : delay_sel;
    clr_s     = flush | (eff_sel_s != sel_q);
    sel_d     = eff_sel_s;
  end

  // Fill counter saturates at MAX_DEPTH; primed compares against the new select.
  always_comb begin
    if (clr_s) begin
      fill_d = '0;
    end else if (ce && (fill_q != FILL_MAX)) begin
      fill_d = fill_q + FW'(1);
    end else begin
      fill_d = fill_q;
    end
    primed_d = (fill_d >= (FW'(sel_d) + FW'(1)));
  end

  // Select, fill count and primed registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      fill_q   <= fill_d;
      primed_q <= primed_d;
    end
  end

  assign primed = primed_q;

  // Colour channel lanes; data is never cleared by flush.
  for (genvar k = 0; k < CH; k++) begin : g_data
    pixdly_lane #(.W(DW), .DEPTH(MAX_DEPTH), .SELW(SELW)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .clr   (1'b0),
      .sel   (sel_q),
      .din   (in_data[lane_lsb(k, DW) +: DW]),
      .dout  (out_data[lane_lsb(k, DW) +: DW])
    );
  end

  // Valid lane: the only lane cleared by flush or delay change.
  pixdly_lane #(.W(1), .DEPTH(MAX_DEPTH), .SELW(SELW)) u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .clr   (clr_s),
    .sel   (sel_q),
    .din   (in_valid),
    .dout  (out_valid)
  );

`ifdef PIXDLY_SIDEBAND_EN
  // Sideband lane follows the pixel with identical latency and stall rules.
  pixdly_lane #(.W(CW), .DEPTH(MAX_DEPTH), .SELW(SELW)) u_side (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .clr   (1'b0),
    .sel   (sel_q),
    .din   (in_c),
    .dout  (out_c)
  );
`else
  logic unused_c_s;
  assign unused_c_s = ^in_c;
  assign out_c      = '0;
`endif

endmodule

// File: tb/tb_pixel_delay_line.sv
// Scoreboard bench for pixel_delay_line: the stimulus pushes each surviving
// sample with the advance count at which it must appear; a monitor on the
// falling edge pops and compares whenever an output is due or valid.
module tb_pixel_delay_line;

  localparam int CH   = 3;
  localparam int DW   = 8;
  localparam int CW   = 3;
  localparam int MD   = 8;
  localparam int SELW = 4;

  typedef struct {
    logic [23:0] d;
    logic [2:0]  c;
    int          due;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            ce;
  logic            flush;
  logic [SELW-1:0] delay_sel;
  logic            in_valid;
  logic [23:0]     in_data;
  logic [2:0]      in_c;
  logic            out_valid;
  logic [23:0]     out_data;
  logic [2:0]      out_c;
  logic            primed;

  exp_t        q[$];
  exp_t        e;
  exp_t        last_e;
  int          last_adv;
  int          adv;
  int          cur_eff;
  int          checks;
  int          errors;
  logic [23:0] dval;

  pixel_delay_line #(.CH(CH), .DW(DW), .CW(CW), .MAX_DEPTH(MD), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .flush     (flush),
    .delay_sel (delay_sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_c     (out_c),
    .primed    (primed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count ce=1 advances seen by the DUT.
  initial begin
    adv = 0;
    forever begin
      @(posedge clk);
      if (rst_n && ce) adv = adv + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] expc(input logic [2:0] c);
`ifdef PIXDLY_SIDEBAND_EN
    return c;
`else
    return 3'b000 & c;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // One clock of stimulus; kill marks an edge that acts as a flush.
  task automatic step(input logic c_e, input logic v, input logic fl, input logic kill,
                      input logic [23:0] d, input logic [2:0] c);
    ce       = c_e;
    in_valid = v;
    flush    = fl;
    in_data  = d;
    in_c     = c;
    if (kill) begin
      while (q.size() > 0 && q[q.size()-1].due > adv) void'(q.pop_back());
    end else if (c_e && v) begin
      q.push_back('{d: d, c: expc(c), due: adv + cur_eff + 2});
    end
    @(posedge clk);
    #2;
  endtask

  task automatic stream();
    step(1'b1, 1'b1, 1'b0, 1'b0, dval, dval[2:0]);
    dval = dval + 24'h000001;
  endtask

  // Monitor: compare due samples, stall holds, and catch stray valids.
  initial begin
    last_adv = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_adv = -1;
      end else if (q.size() > 0 && q[0].due <= adv) begin
        e = q.pop_front();
        checks = checks + 1;
        if (out_valid !== 1'b1 || out_data !== e.d || out_c !== e.c || e.due != adv) begin
          errors = errors + 1;
          $display("FAIL sb_sample adv=%0d due=%0d valid=%b data=%h expected %h c=%b expected %b",
                   adv, e.due, out_valid, out_data, e.d, out_c, e.c);
        end
        last_e   = e;
        last_adv = adv;
      end else if (out_valid === 1'b1) begin
        checks = checks + 1;
        if (adv == last_adv) begin
          if (out_data !== last_e.d || out_c !== last_e.c) begin
            errors = errors + 1;
            $display("FAIL sb_hold data=%h expected %h c=%b expected %b",
                     out_data, last_e.d, out_c, last_e.c);
          end
        end else begin
          errors = errors + 1;
          $display("FAIL sb_unexpected_valid adv=%0d data=%h", adv, out_data);
        end
      end
    end
  end

  initial begin
    int sweep [4];
    checks    = 0;
    errors    = 0;
    dval      = 24'h000100;
    rst_n     = 1'b0;
    ce        = 1'b0;
    flush     = 1'b0;
    delay_sel = 4'd0;
    in_valid  = 1'b0;
    in_data   = 24'h000000;
    in_c      = 3'b000;
    cur_eff   = 0;
    sweep     = '{0, 3, 6, 7};

    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_data", out_data, 24'h000000);
    chk("reset_c", out_c, 3'b000);
    chk("reset_primed", primed, 1'b0);
    rst_n = 1'b1;

    // Latency sweep: marker follows a flush, primed after eff+1 advances.
    foreach (sweep[s]) begin
      delay_sel = SELW'(sweep[s]);
      cur_eff   = sweep[s];
      step(1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 3'b000);
      chk("sweep_flush_primed", primed, 1'b0);
      for (int k = 0; k <= sweep[s] + 1; k++) begin
        if (k == 0) step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0A0B0C, 3'b101);
        else stream();
        chk("sweep_primed", primed, (k >= sweep[s]) ? 1'b1 : 1'b0);
      end
      chk("sweep_marker_valid", out_valid, 1'b1);
      chk("sweep_marker_data", out_data, 24'h0A0B0C);
    end

    // Asynchronous reset mid-stream, no clock edge needed.
    stream();
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", out_valid, 1'b0);
    chk("midreset_data", out_data, 24'h000000);
    chk("midreset_primed", primed, 1'b0);
    q.delete();
    in_valid  = 1'b0;
    delay_sel = 4'd2;
    cur_eff   = 2;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 24'h000000, 3'b000);
    for (int k = 0; k < 4; k++) begin
      stream();
      chk("postreset_primed", primed, (k >= 2) ? 1'b1 : 1'b0);
      if (k == 2) chk("postreset_not_yet_valid", out_valid, 1'b0);
    end

    // Stall pattern 1,0,0,1,1,1 at delay 2: outputs and primed hold.
    begin
      logic [5:0] pat;
      pat = 6'b111001;
      for (int i = 0; i < 6; i++) begin
        step(pat[i], 1'b1, 1'b0, 1'b0, dval, dval[2:0]);
        dval = dval + 24'h000001;
        chk("stall_primed", primed, 1'b1);
      end
    end
    repeat (3) stream();

    // Flush while stalled is still honoured.
    step(1'b0, 1'b1, 1'b1, 1'b1, dval, 3'b000);
    chk("stallflush_valid", out_valid, 1'b0);
    chk("stallflush_primed", primed, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      stream();
      chk("stallflush_reprime", primed, (j >= 3) ? 1'b1 : 1'b0);
    end

    // Flush at delay 4: five empty advances, then intact data.
    delay_sel = 4'd4;
    cur_eff   = 4;
    step(1'b1, 1'b0, 1'b0, 1'b1, 24'h000000, 3'b000);
    repeat (6) stream();
    step(1'b1, 1'b1, 1'b1, 1'b1, 24'hDEAD00, 3'b111);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_primed", primed, 1'b0);
    for (int j = 1; j <= 7; j++) begin
      stream();
      chk("flush_gap_valid", out_valid, (j >= 6) ? 1'b1 : 1'b0);
      chk("flush_reprime", primed, (j >= 5) ? 1'b1 : 1'b0);
    end

    // Delay change 2 -> 5 drops valid on the same edge.
    delay_sel = 4'd2;
    cur_eff   = 2;
    step(1'b1, 1'b0, 1'b0, 1'b1, 24'h000000, 3'b000);
    repeat (5) stream();
    chk("chg_pre_valid", out_valid, 1'b1);
    delay_sel = 4'd5;
    cur_eff   = 5;
    step(1'b1, 1'b1, 1'b0, 1'b1, 24'hBEEF00, 3'b010);
    chk("chg_drop_valid", out_valid, 1'b0);
    for (int j = 1; j <= 7; j++) begin
      stream();
      chk("chg_resume_valid", out_valid, (j >= 7) ? 1'b1 : 1'b0);
    end

    // Out-of-range select 9 clamps to 7; sideband marker 3'b101.
    delay_sel = 4'd9;
    cur_eff   = 7;
    step(1'b1, 1'b0, 1'b0, 1'b1, 24'h000000, 3'b000);
    for (int j = 1; j <= 10; j++) begin
      if (j == 1) step(1'b1, 1'b1, 1'b0, 1'b0, 24'h5A5A5A, 3'b101);
      else stream();
      chk("clamp_valid", out_valid, (j >= 9) ? 1'b1 : 1'b0);
      if (j == 8) chk("clamp_primed", primed, 1'b1);
      if (j == 9) begin
        chk("clamp_marker_data", out_data, 24'h5A5A5A);
        chk("sideband_marker", out_c, expc(3'b101));
      end
    end

    // Drain remaining expected samples within a bounded number of cycles.
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 3'b000);
    end
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
